bfm_ahbmaster_lite: RTL and testbench

- Single-master AHB-Lite transaction engine.
- Sits directly upstream of the AHB slave BFM and drives its HSEL/HADDR/HTRANS/HWDATA side.
- Accepts one command per cycle on a valid/ready interface and issues single (non-burst) transfers with full address/data-phase pipelining.
- Returns read data and response status in issue order.

---
 rtl/bfm_ahbmaster_lite.sv | 192 +++++++++++++++++++
 tb/tb_bfm_ahbmaster_lite.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfm_ahbmaster_lite.sv
// bfm_ahbmaster_lite: single-master AHB-Lite transaction engine.
// Accepts one command per cycle, issues SINGLE transfers with overlapped
// address/data phases and returns responses in issue order.
// Optional feature macro: AHBM_TIMEOUT_EN (data-phase timeout abort, HUNG).
module bfm_ahbmaster_lite #(
  parameter int AWIDTH  = 10,
  parameter int TIMEOUT = 256,
  parameter int TPD     = 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [2:0]        CMD_SIZE,
  input  logic [31:0]       CMD_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic              BUSY,
  output logic              HUNG,
  output logic              HSEL,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADYIN,
  input  logic              HRESP
);

  // Output delays are a simulation-only notion and are not modelled in this
  // synthesizable view; TIMEOUT is only consumed when the timeout is built in.
  localparam int cfg_unused = TPD + TIMEOUT;

  // Address-phase register (A)
  logic              a_valid_r;
  logic [AWIDTH-1:0] a_addr_r;
  logic              a_write_r;
  logic [2:0]        a_size_r;
  logic [31:0]       a_wdata_r;

  // Data-phase register (D)
  logic              d_valid_r;
  logic              d_write_r;
  logic [31:0]       d_wdata_r;

  // Second cycle of a two-cycle ERROR response: hold off the next address.
  logic              cancel_r;

  // Registered response
  logic              rsp_valid_r;
  logic [31:0]       rsp_rdata_r;
  logic              rsp_err_r;

  logic              cmd_ready_s;
  logic              accept_s;
  logic              advance_s;
  logic              complete_s;
  logic              err_first_s;
  logic              abort_s;
  logic              hung_s;

`ifdef AHBM_TIMEOUT_EN
  logic [15:0] to_cnt_r;
  logic        hung_r;

  // The abort fires on the edge that samples the TIMEOUT-th low HREADY cycle.
  assign abort_s = d_valid_r & ~HREADYIN & (to_cnt_r == 16'(TIMEOUT - 1));
  assign hung_s  = hung_r;

  // Count consecutive wait cycles of the current data phase; latch the hang.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      to_cnt_r <= 16'd0;
      hung_r   <= 1'b0;
    end else begin
      if (d_valid_r & ~HREADYIN & ~abort_s) begin
        to_cnt_r <= to_cnt_r + 16'd1;
      end else begin
        to_cnt_r <= 16'd0;
      end
      if (abort_s) begin
        hung_r <= 1'b1;
      end
    end
  end
`else
  assign abort_s = 1'b0;
  assign hung_s  = 1'b0;
`endif

  // Ready also drops on the abort edge so no command is accepted and then lost.
  assign cmd_ready_s = ~HRESET & ~hung_s & ~cancel_r & ~abort_s & (~a_valid_r | HREADYIN);
  assign accept_s    = CMD_VALID & cmd_ready_s;
  assign advance_s   = a_valid_r & HREADYIN & ~cancel_r;
  assign complete_s  = d_valid_r & HREADYIN;
  assign err_first_s = d_valid_r & HRESP & ~HREADYIN;

  // Move commands through the address and data phases.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_valid_r <= 1'b0;
      a_addr_r  <= '0;
      a_write_r <= 1'b0;
      a_size_r  <= 3'd0;
      a_wdata_r <= 32'd0;
      d_valid_r <= 1'b0;
      d_write_r <= 1'b0;
      d_wdata_r <= 32'd0;
    end else begin
      if (abort_s) begin
        a_valid_r <= 1'b0;
      end else if (accept_s) begin
        a_valid_r <= 1'b1;
        a_addr_r  <= CMD_ADDR;
        a_write_r <= CMD_WRITE;
        a_size_r  <= CMD_SIZE;
        a_wdata_r <= CMD_WDATA;
      end else if (advance_s) begin
        a_valid_r <= 1'b0;
      end

      if (abort_s) begin
        d_valid_r <= 1'b0;
      end else if (advance_s) begin
        d_valid_r <= 1'b1;
        d_write_r <= a_write_r;
        d_wdata_r <= a_wdata_r;
      end else if (complete_s) begin
        d_valid_r <= 1'b0;
      end
    end
  end

  // Track the second cycle of an ERROR response.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cancel_r <= 1'b0;
    end else if (abort_s) begin
      cancel_r <= 1'b0;
    end else if (err_first_s) begin
      cancel_r <= 1'b1;
    end else if (HREADYIN) begin
      cancel_r <= 1'b0;
    end
  end

  // Capture one response per completed (or aborted) data phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'd0;
    end else begin
      rsp_valid_r <= complete_s | abort_s;
      if (abort_s) begin
        rsp_err_r   <= 1'b1;
        rsp_rdata_r <= 32'hDEAD_BEEF;
      end else if (complete_s) begin
        rsp_err_r   <= HRESP;
        rsp_rdata_r <= d_write_r ? 32'd0 : HRDATA;
      end else begin
        rsp_err_r   <= 1'b0;
        rsp_rdata_r <= 32'd0;
      end
    end
  end

  assign CMD_READY = cmd_ready_s;
  assign RSP_VALID = rsp_valid_r;
  assign RSP_RDATA = rsp_rdata_r;
  assign RSP_ERR   = rsp_err_r;
  assign BUSY      = a_valid_r | d_valid_r;
  assign HUNG      = hung_s;

  assign HTRANS    = (a_valid_r & ~cancel_r) ? 2'b10 : 2'b00;
  assign HSEL      = HTRANS[1];
  assign HADDR     = a_addr_r;
  assign HWRITE    = a_write_r;
  assign HSIZE     = a_size_r;
  assign HWDATA    = d_wdata_r;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;

endmodule

// File: tb/tb_bfm_ahbmaster_lite.sv
// Testbench for bfm_ahbmaster_lite: the bench plays the AHB slave (word memory,
// scripted wait states / errors) and checks every cycle against a bus-level
// model built from queues of accepted and in-flight commands.
module tb_bfm_ahbmaster_lite;
  localparam int AW = 10;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          CMD_VALID, CMD_READY, CMD_WRITE;
  logic [AW-1:0] CMD_ADDR;
  logic [2:0]    CMD_SIZE;
  logic [31:0]   CMD_WDATA;
  logic          RSP_VALID, RSP_ERR, BUSY, HUNG, HSEL, HWRITE, HMASTLOCK;
  logic [31:0]   RSP_RDATA, HWDATA, HRDATA;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic          HREADYIN, HRESP;

  always #5 HCLK = ~HCLK;

  bfm_ahbmaster_lite #(.AWIDTH(AW), .TIMEOUT(8), .TPD(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .BUSY(BUSY), .HUNG(HUNG), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYIN(HREADYIN),
    .HRESP(HRESP)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [31:0]   wdata;
    int            gap;      // idle cycles before this command is offered
    int            waits;    // slave wait states in its data phase
    logic          err;      // slave answers ERROR
    logic          has_exp;
    logic          exp_err;
    logic [31:0]   exp_rdata;
  } cmd_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        has_exp;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } rsp_t;

  cmd_t        stim_q[$];   // not yet accepted
  cmd_t        aq[$];       // accepted, address phase not yet taken by the bus
  rsp_t        exp_q[$];    // completed on the last edge, response due now
  cmd_t        dp;
  bit          dp_active;
  int          dp_wait;
  bit          dp_stage;    // 1 = second cycle of ERROR response
  int          gap_cnt;
  logic [31:0] mem [256];
  cmd_t        vec [17];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(logic wr, logic [AW-1:0] a, logic [2:0] s, logic [31:0] d,
                              int gap, int waits, logic err, logic ee, logic [31:0] er);
    cmd_t c;
    c.wr = wr; c.addr = a; c.size = s; c.wdata = d; c.gap = gap; c.waits = waits;
    c.err = err; c.has_exp = 1'b1; c.exp_err = ee; c.exp_rdata = er;
    return c;
  endfunction

  function automatic void mem_write(logic [AW-1:0] a, logic [2:0] s, logic [31:0] d);
    logic [31:0] w;
    w = mem[a[AW-1:2]];
    for (int b = 0; b < 4; b++) begin
      if (s == 3'd2 || (s == 3'd1 && (b / 2) == int'(a[1])) || (s == 3'd0 && b == int'(a[1:0])))
        w[b*8 +: 8] = d[b*8 +: 8];
    end
    mem[a[AW-1:2]] = w;
  endfunction

  task automatic push(input cmd_t c);
    if (stim_q.size() == 0) gap_cnt = c.gap;
    stim_q.push_back(c);
  endtask

  // One bus cycle; entered and left at posedge+1.
  task automatic step();
    rsp_t        nr;
    bit          present, accept, taken, complete, cancel_m, exp_ready;
    logic [31:0] rd_s;
    logic [1:0]  exp_trans;

    if (exp_q.size() > 0) begin
      nr = exp_q.pop_front();
      chk("rsp_valid", 32'(RSP_VALID), 32'd1);
      chk("rsp_err", 32'(RSP_ERR), 32'(nr.err));
      chk("rsp_rdata", RSP_RDATA, nr.rdata);
      if (nr.has_exp) begin
        chk("vec_err", 32'(RSP_ERR), 32'(nr.exp_err));
        chk("vec_rdata", RSP_RDATA, nr.exp_rdata);
      end
    end else begin
      chk("rsp_idle", 32'(RSP_VALID), 32'd0);
    end

    present   = (stim_q.size() > 0) && (gap_cnt == 0);
    CMD_VALID = present;
    if (present) begin
      CMD_WRITE = stim_q[0].wr;   CMD_ADDR  = stim_q[0].addr;
      CMD_SIZE  = stim_q[0].size; CMD_WDATA = stim_q[0].wdata;
    end else begin
      CMD_WRITE = 1'($urandom());  CMD_ADDR  = AW'($urandom());
      CMD_SIZE  = 3'($urandom());  CMD_WDATA = $urandom();
    end

    cancel_m = dp_active && dp_stage;
    if (!dp_active) begin
      HREADYIN = 1'b1; HRESP = 1'b0;
    end else if (dp_wait > 0) begin
      HREADYIN = 1'b0; HRESP = 1'b0;
    end else if (dp.err && !dp_stage) begin
      HREADYIN = 1'b0; HRESP = 1'b1;
    end else begin
      HREADYIN = 1'b1; HRESP = dp.err;
    end
    rd_s   = (dp_active && !dp.wr) ? mem[dp.addr[AW-1:2]] : $urandom();
    HRDATA = rd_s;
    #1;

    exp_ready = ((aq.size() == 0) || HREADYIN) && !cancel_m;
    exp_trans = (aq.size() > 0 && !cancel_m) ? 2'b10 : 2'b00;
    chk("cmd_ready", 32'(CMD_READY), 32'(exp_ready));
    chk("htrans", 32'(HTRANS), 32'(exp_trans));
    chk("hsel", 32'(HSEL), 32'(exp_trans[1]));
    chk("busy", 32'(BUSY), 32'((aq.size() > 0) || dp_active));
    chk("hung", 32'(HUNG), 32'd0);
    if (dp_active && dp.wr) chk("hwdata", HWDATA, dp.wdata);
    if (aq.size() > 0 && !cancel_m) begin
      chk("haddr", 32'(HADDR), 32'(aq[0].addr));
      chk("hwrite", 32'(HWRITE), 32'(aq[0].wr));
      chk("hsize", 32'(HSIZE), 32'(aq[0].size));
    end

    accept   = present && exp_ready;
    taken    = (aq.size() > 0) && !cancel_m && HREADYIN;
    complete = dp_active && HREADYIN;
    @(posedge HCLK);
    if (complete) begin
      nr.err = dp.err; nr.rdata = dp.wr ? 32'd0 : rd_s;
      nr.has_exp = dp.has_exp; nr.exp_err = dp.exp_err; nr.exp_rdata = dp.exp_rdata;
      exp_q.push_back(nr);
      if (dp.wr && !dp.err) mem_write(dp.addr, dp.size, dp.wdata);
    end else if (dp_active) begin
      if (dp_wait > 0) dp_wait--;
      else dp_stage = 1'b1;
    end
    if (taken) begin
      dp = aq.pop_front(); dp_active = 1'b1; dp_wait = dp.waits; dp_stage = 1'b0;
    end else if (complete) begin
      dp_active = 1'b0;
    end
    if (accept) begin
      aq.push_back(stim_q.pop_front());
      gap_cnt = (stim_q.size() > 0) ? stim_q[0].gap : 0;
    end else if (!present && gap_cnt > 0) begin
      gap_cnt--;
    end
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((stim_q.size() > 0 || aq.size() > 0 || dp_active || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_idle", 32'(stim_q.size() > 0 || aq.size() > 0 || dp_active || exp_q.size() > 0), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_hsel", 32'(HSEL), 32'd0);
    chk("rst_haddr", 32'(HADDR), 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
    chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_hung", 32'(HUNG), 32'd0);
    chk("rst_cmd_ready", 32'(CMD_READY), 32'd0);
    chk("const_hburst", 32'(HBURST), 32'd0);
    chk("const_hmastlock", 32'(HMASTLOCK), 32'd0);
    chk("const_hprot", 32'(HPROT), 32'd3);
  endtask

  initial begin
    cmd_t c;
    int   s;

    // Directed vectors: {write, addr, size, wdata, gap, waits, err, exp_err, exp_rdata}
    vec[0]  = mk(1'b1, 10'h0F0, 3'd2, 32'hA5A5_1234, 0, 0, 1'b0, 1'b0, 32'h0000_0000);
    vec[1]  = mk(1'b0, 10'h0F0, 3'd2, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'hA5A5_1234);
    vec[2]  = mk(1'b1, 10'h0F2, 3'd1, 32'hBEEF_0000, 1, 0, 1'b0, 1'b0, 32'h0000_0000);
    vec[3]  = mk(1'b0, 10'h0F0, 3'd2, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'hBEEF_1234);
    vec[4]  = mk(1'b1, 10'h0F1, 3'd0, 32'h0000_7700, 1, 1, 1'b0, 1'b0, 32'h0000_0000);
    vec[5]  = mk(1'b0, 10'h0F0, 3'd2, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'hBEEF_7734);
    vec[6]  = mk(1'b0, 10'h100, 3'd2, 32'h0000_0000, 2, 0, 1'b0, 1'b0, 32'hC0FF_EE40);
    vec[7]  = mk(1'b0, 10'h104, 3'd2, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'hC0FF_EE41);
    vec[8]  = mk(1'b0, 10'h108, 3'd2, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'hC0FF_EE42);
    vec[9]  = mk(1'b0, 10'h10C, 3'd2, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'hC0FF_EE43);
    vec[10] = mk(1'b0, 10'h0F0, 3'd2, 32'h0000_0000, 2, 3, 1'b0, 1'b0, 32'hBEEF_7734);
    vec[11] = mk(1'b0, 10'h104, 3'd2, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'hC0FF_EE41);
    vec[12] = mk(1'b1, 10'h0F0, 3'd2, 32'h0000_0000, 1, 0, 1'b1, 1'b1, 32'h0000_0000);
    vec[13] = mk(1'b0, 10'h0F0, 3'd2, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'hBEEF_7734);
    vec[14] = mk(1'b0, 10'h0F0, 3'd2, 32'h0000_0000, 0, 0, 1'b1, 1'b1, 32'hBEEF_7734);
    vec[15] = mk(1'b1, 10'h3FC, 3'd2, 32'h1234_5678, 1, 0, 1'b0, 1'b0, 32'h0000_0000);
    vec[16] = mk(1'b0, 10'h3FC, 3'd2, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h1234_5678);

    for (int i = 0; i < 256; i++) mem[i] = 32'hC0FF_EE00 | 32'(i);
    dp_active = 1'b0; dp_wait = 0; dp_stage = 1'b0; gap_cnt = 0;

    HRESET = 1'b1; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0;
    CMD_SIZE = 3'd0; CMD_WDATA = 32'd0; HRDATA = 32'd0; HREADYIN = 1'b1; HRESP = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Directed table through the slave model
    for (int i = 0; i < 17; i++) push(vec[i]);
    drain(200);

    // Reset in the middle of a wait-stated data phase
    c = mk(1'b0, 10'h0F0, 3'd2, 32'd0, 0, 8, 1'b0, 1'b0, 32'd0);
    c.has_exp = 1'b0;
    push(c);
    repeat (4) step();
    #2;
    HRESET = 1'b1;
    #1;
    chk_reset_vals();
    stim_q.delete(); aq.delete(); exp_q.delete();
    dp_active = 1'b0; dp_stage = 1'b0; gap_cnt = 0;
    CMD_VALID = 1'b0; HREADYIN = 1'b1; HRESP = 1'b0;
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    repeat (4) step();
    c = mk(1'b0, 10'h0F0, 3'd2, 32'd0, 0, 0, 1'b0, 1'b0, 32'hBEEF_7734);
    push(c);
    drain(20);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      c.wr    = 1'($urandom());
      s       = int'($urandom_range(0, 2));
      c.size  = 3'(s);
      c.addr  = AW'($urandom_range(0, 1023));
      if (s == 1) c.addr[0] = 1'b0;
      if (s == 2) c.addr[1:0] = 2'b00;
      c.wdata = $urandom();
      c.gap   = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 2));
      c.waits = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
      c.err   = ($urandom_range(0, 9) == 0);
      c.has_exp = 1'b0; c.exp_err = 1'b0; c.exp_rdata = 32'd0;
      push(c);
    end
    drain(4000);

`ifdef AHBM_TIMEOUT_EN
    // Timeout: two reads in flight, slave never becomes ready again
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 10'h040; CMD_SIZE = 3'd2;
    HREADYIN = 1'b1; HRESP = 1'b0;
    @(posedge HCLK);
    #1;
    CMD_ADDR = 10'h044;
    @(posedge HCLK);
    #1;
    CMD_VALID = 1'b0; HREADYIN = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge HCLK);
      #1;
      chk("to_rsp_valid", 32'(RSP_VALID), 32'(i == 8));
      if (i == 8) begin
        chk("to_rsp_err", 32'(RSP_ERR), 32'd1);
        chk("to_rsp_rdata", RSP_RDATA, 32'hDEAD_BEEF);
      end
    end
    chk("to_hung", 32'(HUNG), 32'd1);
    chk("to_htrans", 32'(HTRANS), 32'd0);
    chk("to_busy", 32'(BUSY), 32'd0);
    HREADYIN = 1'b1; CMD_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("to_cmd_ready", 32'(CMD_READY), 32'd0);
      @(posedge HCLK);
      #1;
      chk("to_rsp_quiet", 32'(RSP_VALID), 32'd0);
      chk("to_htrans_idle", 32'(HTRANS), 32'd0);
      chk("to_hung_sticky", 32'(HUNG), 32'd1);
    end
    CMD_VALID = 1'b0;
    HRESET = 1'b1;
    #1;
    chk("to_hung_cleared", 32'(HUNG), 32'd0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
